// File: rtl/spi_regfile_rw_pkg.sv
// Shared types and constants for the SPI register-file target.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        WR,
        RD
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int unsigned ERR_CNT_W = 8;

    // Total frame length: R/W bit + address field + data field.
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_rw_if.sv
// SPI pin bundle between the controller side and the register-file target.
interface spi_regfile_rw_if;

    logic spi_sclk;
    logic spi_copi;
    logic spi_ncs;
    logic spi_cipo;
    logic spi_cipo_oe;

    modport master (
        output spi_sclk,
        output spi_copi,
        output spi_ncs,
        input  spi_cipo,
        input  spi_cipo_oe
    );

    modport slave (
        input  spi_sclk,
        input  spi_copi,
        input  spi_ncs,
        output spi_cipo,
        output spi_cipo_oe
    );

endinterface

// File: rtl/spi_regfile_rw_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus rise/fall detection.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain and one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 target with read/write access to a bank of control registers.
module spi_regfile_rw
    import spi_regfile_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 7,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_regfile_rw_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [ERR_CNT_W-1:0]         frame_err_cnt
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned HDR_W   = 1 + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0]  CNT_HDR   = CNT_W'(HDR_W);
    localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_OVER  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]   NREGS_L   = (ADDR_W + 1)'(NUM_REGS);

    state_e state_q, state_d;

    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_W-1:0]   sh_q;
    logic [DATA_W-1:0]    sout_q;
    logic                 oe_q;
    logic [1:0]           settle_q;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic                 wr_strobe_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [ERR_CNT_W-1:0] err_q;

    logic sclk_rise, sclk_fall, copi, ncs_rise, ncs_fall_raw, ncs_fall;
    logic sclk_level_unused, copi_rise_unused, copi_fall_unused, ncs_level_unused;

    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;
    logic              commit_ok;
    logic              reject;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_i(spi.spi_sclk),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .async_i(spi.spi_copi),
        .level_o(copi), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .async_i(spi.spi_ncs),
        .level_o(ncs_level_unused), .rise_o(ncs_rise), .fall_o(ncs_fall_raw)
    );

    // The nCS synchroniser restarts at 'deselected'; if reset lands mid-frame the pin
    // is still low and a false falling edge appears two cycles later. Masking falls
    // until the chain has flushed keeps that interrupted frame ignored.
    assign ncs_fall = ncs_fall_raw && (settle_q == 2'd0);

    assign commit_addr = sh_q[DATA_W +: ADDR_W];
    assign commit_data = sh_q[DATA_W-1:0];
    assign rd_addr     = sh_q[ADDR_W-1:0];

    assign commit_ok = ncs_rise && (state_q == WR) && (cnt_q == CNT_FRAME)
                       && (sh_q[FRAME_W-1] == RW_WRITE) && ({1'b0, commit_addr} < NREGS_L);

    assign reject = ncs_rise && (state_q == HDR || state_q == WR) && (cnt_q != '0)
                    && !commit_ok;

    // Read-back mux; out-of-range addresses read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_val = regs_q[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: nCS edges override everything; header end selects WR/RD.
    always_comb begin
        state_d = state_q;
        if (ncs_fall) begin
            state_d = HDR;
        end else if (ncs_rise) begin
            state_d = IDLE;
        end else if (state_q == HDR && cnt_q == CNT_HDR) begin
            case (sh_q[ADDR_W])
                RW_WRITE: state_d = WR;
                RW_READ:  state_d = RD;
            endcase
        end
    end

    // FSM outputs: CIPO only carries shift-out data while reading.
    always_comb begin
        spi.spi_cipo    = (state_q == RD) ? sout_q[DATA_W-1] : 1'b0;
        spi.spi_cipo_oe = oe_q;
    end

    // Bit counter, shift-in/out registers, output enable and post-reset mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sh_q     <= '0;
            sout_q   <= '0;
            oe_q     <= 1'b0;
            settle_q <= 2'd3;
        end else begin
            if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
            if (ncs_fall) begin
                cnt_q <= '0;
                sh_q  <= '0;
                oe_q  <= 1'b1;
            end else if (ncs_rise) begin
                oe_q <= 1'b0;
            end else if (sclk_rise && state_q != IDLE) begin
                sh_q <= {sh_q[FRAME_W-2:0], copi};
                if (cnt_q != CNT_OVER) cnt_q <= cnt_q + CNT_W'(1);
            end
            // The fall that follows the last header bit must not shift: the MSB
            // has only just been presented and is sampled on the next rise.
            if (state_q == HDR && state_d == RD) begin
                sout_q <= rd_val;
            end else if (state_q == RD && sclk_fall && cnt_q > CNT_HDR) begin
                sout_q <= {sout_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Register bank and write-commit reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= commit_ok;
            if (commit_ok) begin
                wr_addr_q <= commit_addr;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (commit_addr == ADDR_W'(i)) regs_q[i] <= commit_data;
                end
            end
        end
    end

    // Saturating count of rejected frames.
    always_ff @(posedge clk) begin
        if (rst)                        err_q <= '0;
        else if (reject && err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_strobe     = wr_strobe_q;
    assign wr_addr       = wr_addr_q;
    assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Scoreboard bench for spi_regfile_rw: default build (dut_a) and a 4/16/8 build (dut_b).
`timescale 1ns/1ps
module tb_spi_regfile_rw;

    localparam int HP = 6;  // SCLK half-period in clk cycles

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic rst_a, rst_b;
    spi_regfile_rw_if ifa();
    spi_regfile_rw_if ifb();

    logic [39:0]  regs_a;  logic wstb_a; logic [6:0] waddr_a; logic [7:0] err_a;
    logic [127:0] regs_b;  logic wstb_b; logic [3:0] waddr_b; logic [7:0] err_b;

    spi_regfile_rw dut_a (
        .clk(clk), .rst(rst_a), .spi(ifa.slave), .regs_o(regs_a),
        .wr_strobe(wstb_a), .wr_addr(waddr_a), .frame_err_cnt(err_a)
    );

    spi_regfile_rw #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(8)) dut_b (
        .clk(clk), .rst(rst_b), .spi(ifb.slave), .regs_o(regs_b),
        .wr_strobe(wstb_b), .wr_addr(waddr_b), .frame_err_cnt(err_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model
    logic [7:0]  mdl_a [5];
    logic [15:0] mdl_b [8];
    int          exp_err_a = 0;

    // Scoreboard queues: expectations pushed with stimulus, observations from monitor
    int           exp_addr_a[$];  logic [39:0]  exp_regs_a[$];
    int           exp_addr_b[$];  logic [127:0] exp_regs_b[$];
    logic         exp_bits[$];
    int           obs_addr_a[$];  logic [39:0]  obs_regs_a[$];
    int           obs_addr_b[$];  logic [127:0] obs_regs_b[$];
    int           long_a = 0, long_b = 0;
    logic         prev_a = 1'b0, prev_b = 1'b0;

    function automatic logic [39:0] pack_a();
        logic [39:0] v;
        for (int i = 0; i < 5; i++) v[i*8 +: 8] = mdl_a[i];
        return v;
    endfunction

    function automatic logic [127:0] pack_b();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = mdl_b[i];
        return v;
    endfunction

    // Strobe monitor: logs each committed write and any strobe longer than one cycle
    always @(negedge clk) begin
        if (wstb_a) begin
            obs_addr_a.push_back(int'(waddr_a));
            obs_regs_a.push_back(regs_a);
            if (prev_a) long_a++;
        end
        if (wstb_b) begin
            obs_addr_b.push_back(int'(waddr_b));
            obs_regs_b.push_back(regs_b);
            if (prev_b) long_b++;
        end
        prev_a = wstb_a;
        prev_b = wstb_b;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pins(input bit sel, input logic sclk, input logic copi, input logic ncs);
        if (sel) begin
            ifb.spi_sclk = sclk; ifb.spi_copi = copi; ifb.spi_ncs = ncs;
        end else begin
            ifa.spi_sclk = sclk; ifa.spi_copi = copi; ifa.spi_ncs = ncs;
        end
    endtask

    function automatic logic cipo_of(input bit sel);
        return sel ? ifb.spi_cipo : ifa.spi_cipo;
    endfunction

    function automatic logic oe_of(input bit sel);
        return sel ? ifb.spi_cipo_oe : ifa.spi_cipo_oe;
    endfunction

    // One SPI mode-0 frame, MSB first; CIPO sampled just before each rising edge.
    // rst_at >= 0 pulses that DUT's reset after the given bit index.
    task automatic xfer(input bit sel, input logic [31:0] bits, input int n, input int rst_at,
                        output logic [31:0] rx, output logic oe_mid);
        logic c;
        rx = '0;
        oe_mid = 1'b0;
        pins(sel, 1'b0, 1'b0, 1'b1);
        clks(2);
        pins(sel, 1'b0, 1'b0, 1'b0);
        clks(HP);
        for (int i = 0; i < n; i++) begin
            c = bits[n-1-i];
            pins(sel, 1'b0, c, 1'b0);
            clks(HP);
            rx = {rx[30:0], cipo_of(sel)};
            if (i == 0) oe_mid = oe_of(sel);
            pins(sel, 1'b1, c, 1'b0);
            clks(HP);
            pins(sel, 1'b0, c, 1'b0);
            if (i == rst_at) begin
                if (sel) rst_b = 1'b1; else rst_a = 1'b1;
                clks(3);
                rst_a = 1'b0;
                rst_b = 1'b0;
            end
        end
        clks(HP);
        pins(sel, 1'b0, 1'b0, 1'b1);
        clks(2 * HP + 4);
    endtask

    task automatic test_reset();
        pins(0, 1'b0, 1'b0, 1'b1);
        pins(1, 1'b0, 1'b0, 1'b1);
        rst_a = 1'b1; rst_b = 1'b1;
        clks(5);
        rst_a = 1'b0; rst_b = 1'b0;
        clks(2);
        for (int i = 0; i < 5; i++) mdl_a[i] = 8'h00;
        for (int i = 0; i < 8; i++) mdl_b[i] = 16'h0000;
        n_chk++; if (regs_a !== 40'h0) $display("FAIL reset_regs_a: got %h want %h", regs_a, 40'h0); else n_pass++;
        n_chk++; if (wstb_a !== 1'b0) $display("FAIL reset_strobe: got %b want 0", wstb_a); else n_pass++;
        n_chk++; if (waddr_a !== 7'd0) $display("FAIL reset_wr_addr: got %0d want 0", waddr_a); else n_pass++;
        n_chk++; if (err_a !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_a); else n_pass++;
        n_chk++; if (ifa.spi_cipo !== 1'b0) $display("FAIL reset_cipo: got %b want 0", ifa.spi_cipo); else n_pass++;
        n_chk++; if (ifa.spi_cipo_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", ifa.spi_cipo_oe); else n_pass++;
        n_chk++; if (regs_b !== 128'h0) $display("FAIL reset_regs_b: got %h want 0", regs_b); else n_pass++;
    endtask

    task automatic test_write();
        logic [31:0] rx; logic oe; int ea, oa; logic [39:0] er, orr;
        mdl_a[1] = 8'hA5;
        exp_addr_a.push_back(1); exp_regs_a.push_back(pack_a());
        xfer(0, 32'({1'b1, 7'd1, 8'hA5}), 16, -1, rx, oe);
        while (exp_addr_a.size() > 0) begin
            ea = exp_addr_a.pop_front(); er = exp_regs_a.pop_front();
            n_chk++;
            if (obs_addr_a.size() == 0) $display("FAIL write_strobe: no strobe, want addr %0d", ea);
            else begin
                oa = obs_addr_a.pop_front(); orr = obs_regs_a.pop_front();
                if (oa !== ea || orr !== er) $display("FAIL write_commit: got addr %0d regs %h want addr %0d regs %h", oa, orr, ea, er);
                else n_pass++;
            end
        end
        n_chk++; if (obs_addr_a.size() != 0) $display("FAIL write_extra_strobe: got %0d want 0", obs_addr_a.size()); else n_pass++;
        n_chk++; if (long_a != 0) $display("FAIL write_strobe_width: got %0d long want 0", long_a); else n_pass++;
        n_chk++; if (oe !== 1'b1) $display("FAIL write_oe: got %b want 1", oe); else n_pass++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL write_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] rx; logic oe; logic eb;
        for (int k = 7; k >= 0; k--) exp_bits.push_back(mdl_a[1][k]);
        xfer(0, 32'({1'b0, 7'd1, 8'h00}), 16, -1, rx, oe);
        for (int k = 7; k >= 0; k--) begin
            eb = exp_bits.pop_front();
            n_chk++; if (rx[k] !== eb) $display("FAIL read_bit%0d: got %b want %b", k, rx[k], eb); else n_pass++;
        end
        n_chk++; if (regs_a !== pack_a()) $display("FAIL read_regs: got %h want %h", regs_a, pack_a()); else n_pass++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL read_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
        n_chk++; if (obs_addr_a.size() != 0) $display("FAIL read_strobe: got %0d want 0", obs_addr_a.size()); else n_pass++;
    endtask

    task automatic test_frame_len();
        logic [31:0] rx; logic oe;
        xfer(0, 32'({1'b1, 7'd0, 7'h55}), 15, -1, rx, oe);
        exp_err_a++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL short_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
        xfer(0, 32'({1'b1, 7'd0, 8'h3C, 1'b1}), 17, -1, rx, oe);
        exp_err_a++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL long_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
        n_chk++; if (regs_a !== pack_a()) $display("FAIL len_regs: got %h want %h", regs_a, pack_a()); else n_pass++;
        n_chk++; if (obs_addr_a.size() != 0) $display("FAIL len_strobe: got %0d want 0", obs_addr_a.size()); else n_pass++;
    endtask

    task automatic test_bad_addr();
        logic [31:0] rx; logic oe;
        xfer(0, 32'({1'b1, 7'd5, 8'hFF}), 16, -1, rx, oe);
        exp_err_a++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL badaddr_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
        n_chk++; if (regs_a !== pack_a()) $display("FAIL badaddr_regs: got %h want %h", regs_a, pack_a()); else n_pass++;
        n_chk++; if (obs_addr_a.size() != 0) $display("FAIL badaddr_strobe: got %0d want 0", obs_addr_a.size()); else n_pass++;
        xfer(0, 32'({1'b0, 7'd5, 8'h00}), 16, -1, rx, oe);
        n_chk++; if (rx[7:0] !== 8'h00) $display("FAIL badaddr_read: got %h want 00", rx[7:0]); else n_pass++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL badaddr_read_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
    endtask

    task automatic test_midframe_reset();
        logic [31:0] rx; logic oe; int ea, oa; logic [39:0] er, orr;
        xfer(0, 32'({1'b1, 7'd2, 8'h77}), 16, 8, rx, oe);
        for (int i = 0; i < 5; i++) mdl_a[i] = 8'h00;
        exp_err_a = 0;
        n_chk++; if (regs_a !== pack_a()) $display("FAIL midrst_regs: got %h want %h", regs_a, pack_a()); else n_pass++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL midrst_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
        mdl_a[4] = 8'h5A;
        exp_addr_a.push_back(4); exp_regs_a.push_back(pack_a());
        xfer(0, 32'({1'b1, 7'd4, 8'h5A}), 16, -1, rx, oe);
        while (exp_addr_a.size() > 0) begin
            ea = exp_addr_a.pop_front(); er = exp_regs_a.pop_front();
            n_chk++;
            if (obs_addr_a.size() == 0) $display("FAIL midrst_strobe: no strobe, want addr %0d", ea);
            else begin
                oa = obs_addr_a.pop_front(); orr = obs_regs_a.pop_front();
                if (oa !== ea || orr !== er) $display("FAIL midrst_commit: got addr %0d regs %h want addr %0d regs %h", oa, orr, ea, er);
                else n_pass++;
            end
        end
        n_chk++; if (obs_addr_a.size() != 0) $display("FAIL midrst_extra_strobe: got %0d want 0", obs_addr_a.size()); else n_pass++;
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL midrst_err2: got %0d want %0d", err_a, exp_err_a); else n_pass++;
    endtask

    task automatic test_err_saturate();
        logic [31:0] rx; logic oe;
        xfer(0, 32'h0, 0, -1, rx, oe);
        n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL zero_bit_err: got %0d want %0d", err_a, exp_err_a); else n_pass++;
        for (int f = 1; f <= 300; f++) begin
            xfer(0, 32'h1, 1, -1, rx, oe);
            if (exp_err_a < 255) exp_err_a++;
            if (f == 255 || f == 300) begin
                n_chk++; if (err_a !== 8'(exp_err_a)) $display("FAIL sat_err_f%0d: got %0d want %0d", f, err_a, exp_err_a); else n_pass++;
            end
        end
        n_chk++; if (regs_a !== pack_a()) $display("FAIL sat_regs: got %h want %h", regs_a, pack_a()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rx; logic oe; int ea, oa; logic [39:0] er, orr;
        mdl_a[0] = 8'h3C; exp_addr_a.push_back(0); exp_regs_a.push_back(pack_a());
        xfer(0, 32'({1'b1, 7'd0, 8'h3C}), 16, -1, rx, oe);
        mdl_a[3] = 8'hC3; exp_addr_a.push_back(3); exp_regs_a.push_back(pack_a());
        xfer(0, 32'({1'b1, 7'd3, 8'hC3}), 16, -1, rx, oe);
        while (exp_addr_a.size() > 0) begin
            ea = exp_addr_a.pop_front(); er = exp_regs_a.pop_front();
            n_chk++;
            if (obs_addr_a.size() == 0) $display("FAIL b2b_strobe: no strobe, want addr %0d", ea);
            else begin
                oa = obs_addr_a.pop_front(); orr = obs_regs_a.pop_front();
                if (oa !== ea || orr !== er) $display("FAIL b2b_commit: got addr %0d regs %h want addr %0d regs %h", oa, orr, ea, er);
                else n_pass++;
            end
        end
        n_chk++; if (long_a != 0) $display("FAIL b2b_strobe_width: got %0d long want 0", long_a); else n_pass++;
    endtask

    task automatic test_wide();
        logic [31:0] rx; logic oe; int ea, oa; logic [127:0] er, orr; logic eb;
        mdl_b[7] = 16'hBEEF;
        exp_addr_b.push_back(7); exp_regs_b.push_back(pack_b());
        xfer(1, 32'({1'b1, 4'd7, 16'hBEEF}), 21, -1, rx, oe);
        while (exp_addr_b.size() > 0) begin
            ea = exp_addr_b.pop_front(); er = exp_regs_b.pop_front();
            n_chk++;
            if (obs_addr_b.size() == 0) $display("FAIL wide_strobe: no strobe, want addr %0d", ea);
            else begin
                oa = obs_addr_b.pop_front(); orr = obs_regs_b.pop_front();
                if (oa !== ea || orr !== er) $display("FAIL wide_commit: got addr %0d regs %h want addr %0d regs %h", oa, orr, ea, er);
                else n_pass++;
            end
        end
        n_chk++; if (regs_b[127:112] !== 16'hBEEF) $display("FAIL wide_reg7: got %h want BEEF", regs_b[127:112]); else n_pass++;
        n_chk++; if (long_b != 0) $display("FAIL wide_strobe_width: got %0d long want 0", long_b); else n_pass++;
        for (int k = 15; k >= 0; k--) exp_bits.push_back(mdl_b[7][k]);
        xfer(1, 32'({1'b0, 4'd7, 16'h0000}), 21, -1, rx, oe);
        for (int k = 15; k >= 0; k--) begin
            eb = exp_bits.pop_front();
            n_chk++; if (rx[k] !== eb) $display("FAIL wide_read_bit%0d: got %b want %b", k, rx[k], eb); else n_pass++;
        end
        n_chk++; if (err_b !== 8'd0) $display("FAIL wide_err: got %0d want 0", err_b); else n_pass++;
        n_chk++; if (regs_b !== pack_b()) $display("FAIL wide_regs: got %h want %h", regs_b, pack_b()); else n_pass++;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_frame_len();
        test_bad_addr();
        test_midframe_reset();
        test_err_saturate();
        test_back_to_back();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at time limit, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
